// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Load/store unit front end for an RV32 pipeline. It computes the effective
// address, checks the access width and alignment, issues a single-cycle
// strobe to data memory, waits a bounded time for the acknowledge, and
// returns one registered response (extended load data or an error flag).
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake; ready only while idle
//   is_store, funct3         access kind and RV32 width code
//   base, offset             address operands (offset is a signed imm12)
//   store_data               store source, data in the low bits
//   mem_req, mem_addr        one-cycle strobe and word-aligned address
//   mem_we, mem_wdata        byte enables and lane-replicated store data
//   mem_rdata, mem_ack       read word and completion from memory
//   resp_valid, resp_data    one-cycle response strobe and load result
//   resp_err                 response is an error (alignment, code, timeout)
//   busy                     stall request, high whenever not idle
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [11:0] offset,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Last counter value before the access is abandoned; the counter starts
  // at zero on the first WAIT cycle, so this gives exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [1:0]  ea_lo_reg;
  logic [2:0]  funct3_reg;
  logic        is_store_reg;

  logic        mem_req_reg;
  logic [3:0]  mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_data_reg;
  logic        resp_err_reg;

  // Request decode (valid only while idle)
  logic [31:0] ea;
  logic        code_ok;
  logic        align_ok;
  logic        req_legal;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;

  always_comb begin
    ea = base + {{20{offset[11]}}, offset};

    code_ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: code_ok = 1'b1;
      F3_BU, F3_HU:     code_ok = ~is_store;  // no unsigned stores
      default:          code_ok = 1'b0;
    endcase

    align_ok = 1'b1;
    if (funct3[1:0] == 2'b01) align_ok = ~ea[0];
    if (funct3 == F3_W)       align_ok = (ea[1:0] == 2'b00);

    req_legal = code_ok & align_ok;

    lane_we    = 4'b1111;
    lane_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_we    = 4'b0001 << ea[1:0];
        lane_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_we    = 4'b0011 << ea[1:0];
        lane_wdata = {2{store_data[15:0]}};
      end
      default: begin
        lane_we    = 4'b1111;
        lane_wdata = store_data;
      end
    endcase
  end

  // Load extraction from the word returned by memory
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  always_comb begin
    rd_byte = mem_rdata[{ea_lo_reg, 3'b000} +: 8];
    rd_half = mem_rdata[{ea_lo_reg[1], 4'b0000} +: 16];
    case (funct3_reg)
      F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
      F3_BU:   load_ext = {24'h000000, rd_byte};
      F3_HU:   load_ext = {16'h0000, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wait_cnt_reg   <= 8'd0;
      ea_lo_reg      <= 2'b00;
      funct3_reg     <= 3'b000;
      is_store_reg   <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 4'b0000;
      mem_addr_reg   <= 32'h0;
      mem_wdata_reg  <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else begin
      // Strobes default low; data outputs hold until next written.
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 4'b0000;
      resp_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              ea_lo_reg    <= ea[1:0];
              funct3_reg   <= funct3;
              is_store_reg <= is_store;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= {ea[31:2], 2'b00};
              if (is_store) begin
                mem_we_reg    <= lane_we;
                mem_wdata_reg <= lane_wdata;
              end
              state_reg <= S_ISSUE;
            end else begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_data_reg  <= 32'h0;
              state_reg      <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          wait_cnt_reg <= 8'd0;
          state_reg    <= S_WAIT;
        end

        S_WAIT: begin
          // An ack on the final counted cycle still completes normally.
          if (mem_ack) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= is_store_reg ? 32'h0 : load_ext;
            state_reg      <= S_RESP;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
            resp_data_reg  <= 32'h0;
            state_reg      <= S_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed cases plus randomized requests,
// checked against a behavioural model of address, lane and latency rules.
module tb_mem_access_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [11:0] offset;
  logic [31:0] store_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int txn_id = 0;

  // Tracked "hold" values and last observations for directed checks
  logic [31:0] exp_addr_last  = 32'h0;
  logic [31:0] exp_wdata_last = 32'h0;
  logic [31:0] obs_resp_data;
  logic [31:0] obs_addr_issue;
  logic [3:0]  obs_we_issue;
  logic [31:0] obs_wdata_issue;
  int          obs_latency;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request with a model-derived expectation. ack_delay counts WAIT
  // cycles before the ack; values >= TB_TIMEOUT mean memory never answers.
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [11:0] off, input logic [31:0] sd,
                        input logic [31:0] rd, input int ack_delay);
    logic [31:0] ea, exp_addr, exp_wdata, exp_data, v;
    logic [3:0]  exp_we;
    logic        legal, exp_err, got_resp;
    int          exp_lat, cyc;

    // Behavioural model
    ea = b + {{20{off[11]}}, off};
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (st && (f3 == 3'd4 || f3 == 3'd5)) legal = 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && ea[0]) legal = 1'b0;
    if (f3 == 3'd2 && ea[1:0] != 2'b00) legal = 1'b0;
    exp_addr = ea & 32'hFFFF_FFFC;
    if (f3 == 3'd0) begin
      exp_we = 4'(1 << ea[1:0]);
      exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
    end else if (f3 == 3'd1) begin
      exp_we = 4'(3 << ea[1:0]);
      exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      exp_we = 4'hF;
      exp_wdata = sd;
    end
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * ea[1:0])) & 32'hFF;
        exp_data = (f3 == 3'd0 && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * ea[1])) & 32'hFFFF;
        exp_data = (f3 == 3'd1 && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      end
      default: exp_data = rd;
    endcase
    exp_err = !legal || (ack_delay >= TB_TIMEOUT);
    if (exp_err || st) exp_data = 32'h0;
    exp_lat = !legal ? 1 : ((ack_delay < TB_TIMEOUT) ? 3 + ack_delay : 2 + TB_TIMEOUT);

    // Present request
    check_val("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; is_store = st; funct3 = f3; base = b; offset = off; store_data = sd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    is_store = 1'($urandom); funct3 = 3'($urandom); base = $urandom;

    got_resp = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (resp_valid) begin
        got_resp = 1'b1;
        break;
      end
      check_val("busy", 32'(busy), 32'd1);
      check_val("req_ready_busy", 32'(req_ready), 32'd0);
      check_val("mem_req", 32'(mem_req), 32'(legal && cyc == 1));
      check_val("mem_we", 32'(mem_we), (legal && st && cyc == 1) ? 32'(exp_we) : 32'd0);
      if (cyc == 1) begin
        obs_addr_issue = mem_addr; obs_we_issue = mem_we; obs_wdata_issue = mem_wdata;
        if (legal) begin
          check_val("mem_addr", mem_addr, exp_addr);
          if (st) check_val("mem_wdata", mem_wdata, exp_wdata);
        end
        // Ack during ISSUE must be ignored
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end else begin
        mem_ack = (cyc - 2 == ack_delay);
        mem_rdata = mem_ack ? rd : $urandom;
      end
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check_val("resp_seen", 32'(got_resp), 32'd1);
    obs_latency = cyc;
    if (legal) begin
      exp_addr_last = exp_addr;
      if (st) exp_wdata_last = exp_wdata;
    end
    check_val("latency", 32'(cyc), 32'(exp_lat));
    check_val("resp_err", 32'(resp_err), 32'(exp_err));
    check_val("resp_data", resp_data, exp_data);
    check_val("addr_hold", mem_addr, exp_addr_last);
    check_val("wdata_hold", mem_wdata, exp_wdata_last);
    obs_resp_data = resp_data;
    @(posedge clk);
    @(negedge clk);
    check_val("resp_one_cycle", 32'(resp_valid), 32'd0);
    check_val("data_hold", resp_data, exp_data);
    check_val("idle_again", 32'(req_ready), 32'd1);
    $display("txn %0d: st=%0b f3=%0d ea=%08h legal=%0b delay=%0d lat=%0d err=%0b data=%08h",
             txn_id, st, f3, ea, legal, ack_delay, cyc, resp_err, obs_resp_data);
    txn_id++;
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] b;
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b0; base = 32'h0;
    offset = 12'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_resp_data", resp_data, 32'h0);
    check_val("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LB with negative offset
    do_txn(1'b0, 3'd0, 32'h0000_1000, 12'hFFF, 32'h0, 32'h80FF_0000, 0);
    check_val("lb_addr", obs_addr_issue, 32'h0000_0FFC);
    check_val("lb_data", obs_resp_data, 32'hFFFF_FF80);
    check_val("lb_latency", 32'(obs_latency), 32'd3);

    // SH into upper half
    do_txn(1'b1, 3'd1, 32'h0000_2002, 12'h000, 32'h0000_BEEF, 32'h1234_5678, 1);
    check_val("sh_we", 32'(obs_we_issue), 32'b1100);
    check_val("sh_wdata", obs_wdata_issue, 32'hBEEF_BEEF);
    check_val("sh_data", obs_resp_data, 32'h0);

    // Misaligned LW
    do_txn(1'b0, 3'd2, 32'h0000_1001, 12'h000, 32'h0, 32'hDEAD_BEEF, 0);
    check_val("lw_mis_latency", 32'(obs_latency), 32'd1);

    // Timeout with no ack: 4 WAIT cycles then RESP
    do_txn(1'b0, 3'd2, 32'h0000_3000, 12'h004, 32'h0, 32'h0, 99);
    check_val("timeout_latency", 32'(obs_latency), 32'd6);

    // Address wrap, LBU
    do_txn(1'b0, 3'd4, 32'hFFFF_FFFF, 12'h001, 32'h0, 32'h1234_56A5, 0);
    check_val("wrap_addr", obs_addr_issue, 32'h0);
    check_val("wrap_data", obs_resp_data, 32'h0000_00A5);

    // Reset during WAIT, followed by a late ack
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; base = 32'h0000_0100; offset = 12'h0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_val("rst_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check_val("rst_wait_ready", 32'(req_ready), 32'd1);
    check_val("rst_wait_resp", 32'(resp_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_val("late_ack_resp", 32'(resp_valid), 32'd0);
      check_val("late_ack_busy", 32'(busy), 32'd0);
      check_val("late_ack_mem_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    exp_addr_last = 32'h0;
    exp_wdata_last = 32'h0;
    $display("txn %0d: reset during WAIT, late ack ignored", txn_id);
    txn_id++;

    // Randomized requests
    for (int n = 0; n < 120; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && (f3 == 3'd3 || f3 >= 3'd6)) f3 = 3'd2;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b[1:0] = 2'b00;
      do_txn(1'($urandom), f3, b, ($urandom_range(0, 1) == 1) ? 12'h0 : 12'($urandom),
             $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
